// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, FSM state encodings and status-flag bit
//               positions for the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Opcode encoding; 9..15 are undefined and complete as a zero result
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Bit positions inside the registered flag vector
  localparam int NUM_FLAGS  = 3;
  localparam int FLAG_OVF   = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 2;

  // True for the only multi-cycle opcode
  function automatic logic is_mul_op(input logic [3:0] op);
    return op == OP_MUL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_if
// Description : Request/response handshake bundle of the sequential ALU.
//               master = producer/consumer side, slave = ALU side.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_hi;
  logic             zero;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, op, rs, rt, out_ready,
    input  in_ready, out_valid, r, r_hi, zero, carry, ovf
  );

  modport slave (
    input  in_valid, op, rs, rt, out_ready,
    output in_ready, out_valid, r, r_hi, zero, carry, ovf
  );

endinterface
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : mul_shift_add
// Description : Unsigned iterative shift-add multiplier. Operands load on
//               start; exactly WIDTH iterations follow, after which done
//               pulses for one cycle and product holds the full result.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_shift_add #(
  parameter int WIDTH = 8
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               start,
  input  wire logic [WIDTH-1:0]   a,
  input  wire logic [WIDTH-1:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [2*WIDTH-1:0]      product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc_next;

  // Add the shifted multiplicand when the current multiplier bit is set
  assign acc_next = mplr[0] ? (acc + mcand) : acc;

  // Load on start, then one multiplier bit per cycle for WIDTH cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand <= {{WIDTH{1'b0}}, a};
        mplr  <= b;
        acc   <= '0;
        count <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        acc   <= acc_next;
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
        count <= count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          product <= acc_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU with valid/ready handshake. Single-cycle ops
//               are computed combinationally and registered into the output
//               stage; MUL runs on the iterative shift-add sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  wire logic clk,
  input  wire logic rst_n,
  seq_alu_if.slave  bus
);

  state_e                 state;
  logic                   out_valid_q;
  logic [WIDTH-1:0]       r_q;
  logic [WIDTH-1:0]       r_hi_q;
  logic [NUM_FLAGS-1:0]   flags_q;

  logic                   in_ready;
  logic                   accept;
  logic                   mul_start;
  logic                   mul_busy;
  logic                   mul_done;
  logic [2*WIDTH-1:0]     mul_product;

  logic [WIDTH:0]         sum;
  logic [WIDTH:0]         diff;
  logic [WIDTH-1:0]       alu_r;
  logic                   alu_carry;
  logic                   alu_ovf;
  logic [NUM_FLAGS-1:0]   alu_flags;
  logic [NUM_FLAGS-1:0]   mul_flags;

  // A held result that is being drained this cycle frees the output stage,
  // so HOLD can hand off to a new accept on the same edge as IDLE does.
  assign in_ready  = (state != ST_MUL) && !mul_busy && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign mul_start = accept && is_mul_op(bus.op);

  assign sum  = {1'b0, bus.rs} + {1'b0, bus.rt};
  assign diff = {1'b0, bus.rs} - {1'b0, bus.rt};

  // Single-cycle datapath; undefined opcodes fall through to a zero result
  always_comb begin
    alu_r     = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_r     = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (bus.rs[WIDTH-1] == bus.rt[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.rs[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r     = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (bus.rs[WIDTH-1] != bus.rt[WIDTH-1]) &&
                    (diff[WIDTH-1] != bus.rs[WIDTH-1]);
      end
      OP_AND: alu_r = bus.rs & bus.rt;
      OP_OR:  alu_r = bus.rs | bus.rt;
      OP_XOR: alu_r = bus.rs ^ bus.rt;
      OP_SLT: alu_r = {{(WIDTH-1){1'b0}}, ($signed(bus.rs) < $signed(bus.rt))};
      OP_SHL: alu_r = bus.rs << bus.rt[SHW-1:0];
      OP_SHR: alu_r = bus.rs >> bus.rt[SHW-1:0];
      default: alu_r = '0;
    endcase
    alu_flags             = '0;
    alu_flags[FLAG_ZERO]  = (alu_r == '0);
    alu_flags[FLAG_CARRY] = alu_carry;
    alu_flags[FLAG_OVF]   = alu_ovf;
  end

  // MUL flags look at the full product, not just the low half
  always_comb begin
    mul_flags             = '0;
    mul_flags[FLAG_ZERO]  = (mul_product == '0);
    mul_flags[FLAG_OVF]   = |mul_product[2*WIDTH-1:WIDTH];
  end

  mul_shift_add #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.rs),
    .b       (bus.rt),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM and output stage; reset wins over accept and out_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      r_hi_q      <= '0;
      flags_q     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (state == ST_HOLD && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
          if (accept) begin
            if (is_mul_op(bus.op)) begin
              state       <= ST_MUL;
              out_valid_q <= 1'b0;
            end else begin
              state       <= ST_HOLD;
              out_valid_q <= 1'b1;
              r_q         <= alu_r;
              r_hi_q      <= '0;
              flags_q     <= alu_flags;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state       <= ST_HOLD;
            out_valid_q <= 1'b1;
            r_q         <= mul_product[WIDTH-1:0];
            r_hi_q      <= mul_product[2*WIDTH-1:WIDTH];
            flags_q     <= mul_flags;
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.r         = r_q;
  assign bus.r_hi      = r_hi_q;
  assign bus.zero      = flags_q[FLAG_ZERO];
  assign bus.carry     = flags_q[FLAG_CARRY];
  assign bus.ovf       = flags_q[FLAG_OVF];

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Directed self-checking bench for seq_alu at WIDTH = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  seq_alu_if #(.WIDTH(8)) bus ();

  seq_alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // op, rs, rt, expected r, expected {zero, carry, ovf}
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [2:0] f;
  } vec_t;

  // MUL: rs, rt, expected r_hi, r, {zero, carry, ovf}
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [2:0] f;
  } mvec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.rs       = a;
    bus.rt       = b;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 4'h0;
    bus.rs        = 8'h00;
    bus.rt        = 8'h00;
    bus.out_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    vectors++;
    if ({bus.r_hi, bus.r, bus.zero, bus.carry, bus.ovf} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_result: got r_hi=%h r=%h zco=%b%b%b expected all 0",
               bus.r_hi, bus.r, bus.zero, bus.carry, bus.ovf);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_single_cycle();
    vec_t v [19];
    v[0]  = {4'h0, 8'hFF, 8'h01, 8'h00, 3'b110};
    v[1]  = {4'h0, 8'h7F, 8'h01, 8'h80, 3'b001};
    v[2]  = {4'h0, 8'h80, 8'h80, 8'h00, 3'b111};
    v[3]  = {4'h1, 8'h80, 8'h01, 8'h7F, 3'b001};
    v[4]  = {4'h1, 8'h01, 8'h02, 8'hFF, 3'b010};
    v[5]  = {4'h1, 8'h05, 8'h05, 8'h00, 3'b100};
    v[6]  = {4'h2, 8'hF0, 8'h3C, 8'h30, 3'b000};
    v[7]  = {4'h3, 8'hF0, 8'h3C, 8'hFC, 3'b000};
    v[8]  = {4'h4, 8'hF0, 8'h3C, 8'hCC, 3'b000};
    v[9]  = {4'h4, 8'hAA, 8'hAA, 8'h00, 3'b100};
    v[10] = {4'h5, 8'h80, 8'h01, 8'h01, 3'b000};
    v[11] = {4'h5, 8'h01, 8'h80, 8'h00, 3'b100};
    v[12] = {4'h5, 8'h05, 8'h07, 8'h01, 3'b000};
    v[13] = {4'h6, 8'h81, 8'h09, 8'h02, 3'b000};
    v[14] = {4'h7, 8'h81, 8'h0F, 8'h01, 3'b000};
    v[15] = {4'h6, 8'h01, 8'h07, 8'h80, 3'b000};
    v[16] = {4'h7, 8'h80, 8'h08, 8'h80, 3'b000};
    v[17] = {4'hC, 8'hFF, 8'hFF, 8'h00, 3'b100};
    v[18] = {4'hF, 8'h12, 8'h34, 8'h00, 3'b100};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL sc%0d_pre_valid: got %b expected 0", i, bus.out_valid);
      end
      tick();
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL sc%0d_valid: got %b expected 1", i, bus.out_valid);
      end
      vectors++;
      if ({bus.r_hi, bus.r} !== {8'h00, v[i].r}) begin
        miscompares++;
        $display("FAIL sc%0d_result op=%h: got r_hi=%h r=%h expected r_hi=00 r=%h",
                 i, v[i].op, bus.r_hi, bus.r, v[i].r);
      end
      vectors++;
      if ({bus.zero, bus.carry, bus.ovf} !== v[i].f) begin
        miscompares++;
        $display("FAIL sc%0d_flags op=%h: got zco=%b%b%b expected %b",
                 i, v[i].op, bus.zero, bus.carry, bus.ovf, v[i].f);
      end
      tick();
    end
  endtask

  task automatic test_mul();
    mvec_t m [4];
    m[0] = {8'hFF, 8'hFF, 8'hFE, 8'h01, 3'b001};
    m[1] = {8'h10, 8'h10, 8'h01, 8'h00, 3'b001};
    m[2] = {8'h00, 8'h37, 8'h00, 8'h00, 3'b100};
    m[3] = {8'h0D, 8'h0B, 8'h00, 8'h8F, 3'b000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int early;
      drive(4'h8, m[i].a, m[i].b);
      tick();
      bus.in_valid = 1'b0;
      early = 0;
      for (int k = 1; k < 9; k++) begin
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) early++;
        tick();
      end
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) early++;
      vectors++;
      if (early != 0) begin
        miscompares++;
        $display("FAIL mul%0d_busy: got %0d cycles with out_valid or in_ready high expected 0",
                 i, early);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL mul%0d_latency: got out_valid=%b at accept+9 expected 1", i, bus.out_valid);
      end
      vectors++;
      if ({bus.r_hi, bus.r} !== {m[i].hi, m[i].lo}) begin
        miscompares++;
        $display("FAIL mul%0d_product: got %h%h expected %h%h", i, bus.r_hi, bus.r, m[i].hi, m[i].lo);
      end
      vectors++;
      if ({bus.zero, bus.carry, bus.ovf} !== m[i].f) begin
        miscompares++;
        $display("FAIL mul%0d_flags: got zco=%b%b%b expected %b",
                 i, bus.zero, bus.carry, bus.ovf, m[i].f);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bus.out_ready = 1'b0;
    drive(4'h0, 8'h03, 8'h04);
    tick();
    drive(4'h1, 8'hFF, 8'hFF);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.out_valid !== 1'b1 || bus.r !== 8'h07 || bus.in_ready !== 1'b0) bad++;
      tick();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_hold: got %0d stall cycles not holding r=07 with in_ready=0 expected 0", bad);
    end
    vectors++;
    if (bus.r !== 8'h07) begin
      miscompares++;
      $display("FAIL bp_no_capture: got r=%h expected 07", bus.r);
    end
    drive(4'h4, 8'h0F, 8'h33);
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready_release: got %b expected 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.r !== 8'h3C) begin
      miscompares++;
      $display("FAIL bp_queued_xor: got valid=%b r=%h expected valid=1 r=3C", bus.out_valid, bus.r);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    drive(4'h0, 8'h01, 8'h01);
    tick();
    drive(4'h1, 8'h05, 8'h03);
    vectors++;
    if (bus.r !== 8'h02 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got r=%h in_ready=%b expected r=02 in_ready=1", bus.r, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.r !== 8'h02) begin
      miscompares++;
      $display("FAIL b2b_second: got valid=%b r=%h expected valid=1 r=02", bus.out_valid, bus.r);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int stray;
    // Reset while a result is held under backpressure
    bus.out_ready = 1'b0;
    drive(4'h0, 8'h01, 8'h01);
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.r !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_hold: got valid=%b r=%h expected valid=0 r=00", bus.out_valid, bus.r);
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    // Leave a nonzero result behind, then reset 4 cycles into a MUL
    drive(4'h3, 8'h5A, 8'h00);
    tick();
    bus.in_valid = 1'b0;
    tick();
    drive(4'h8, 8'h0F, 8'h0F);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.r !== 8'h00 || bus.r_hi !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_mul: got valid=%b r_hi=%h r=%h expected valid=0 r_hi=00 r=00",
               bus.out_valid, bus.r_hi, bus.r);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mul_ready: got %b expected 1", bus.in_ready);
    end
    drive(4'h0, 8'h03, 8'h04);
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.r !== 8'h07) begin
      miscompares++;
      $display("FAIL rst_mul_add: got valid=%b r=%h expected valid=1 r=07", bus.out_valid, bus.r);
    end
    tick();
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid !== 1'b0) stray++;
      tick();
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL rst_mul_stray: got %0d cycles of out_valid expected 0", stray);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_cycle();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
